// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and entry type for the register-file writeback path
package wb_pkg;
    localparam int XLEN = 32;
    localparam int AW = 5;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of pending writes with per-entry valid bits exposed for forwarding
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t [DEPTH-1:0]  entries,
    output logic [DEPTH-1:0]       valid,
    output logic [PW-1:0]          rd_ptr,
    output logic [CW-1:0]          count
);
    logic [PW-1:0] wr_ptr;
    // pointer, occupancy and valid bookkeeping; push after pop so a full-buffer push+pop keeps the slot valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // entry payload storage; validity is tracked separately so data needs no reset
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer: arbitrates ALU/LSU results into an in-order write queue for the register file
module regfile_wb_writer
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            wb_stall,
    output logic            regwrite,
    output logic [AW-1:0]   waddr,
    output logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
    output logic [CW-1:0]   pending
);
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic pop, push, lsu_acc, alu_acc;
    wb_entry_t push_entry, head;
    logic [PW-1:0] idx;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .push_entry(push_entry),
        .pop(pop),
        .entries(entries),
        .valid(valid),
        .rd_ptr(rd_ptr),
        .count(count)
    );

    // LSU wins arbitration; a retiring head frees a slot in the same cycle; x0 results are accepted but dropped
    always_comb begin
        pop = (count != '0) && !wb_stall;
        lsu_ready = (count < CW'(DEPTH)) || pop;
        alu_ready = lsu_ready && !lsu_valid;
        lsu_acc = lsu_valid && lsu_ready;
        alu_acc = alu_valid && alu_ready;
        push_entry = lsu_acc ? '{rd: lsu_rd, data: lsu_data} : '{rd: alu_rd, data: alu_data};
        push = (lsu_acc || alu_acc) && (push_entry.rd != REG_ZERO);
        head = entries[rd_ptr];
        regwrite = pop;
        waddr = pop ? head.rd : '0;
        wdata = pop ? head.data : '0;
        pending = count;
    end

    // forwarding search walks oldest to youngest so the last match (youngest) wins
    always_comb begin
        fwd_hit1 = 1'b0;
        fwd_hit2 = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (valid[idx] && raddr1 != REG_ZERO && entries[idx].rd == raddr1) begin
                fwd_hit1 = 1'b1;
                fwd_data1 = entries[idx].data;
            end
            if (valid[idx] && raddr2 != REG_ZERO && entries[idx].rd == raddr2) begin
                fwd_hit2 = 1'b1;
                fwd_data2 = entries[idx].data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_writer.sv
// tb_regfile_wb_writer: queue-level reference model with a decoupled write scoreboard
module tb_regfile_wb_writer;
    import wb_pkg::*;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic alu_valid = 1'b0, lsu_valid = 1'b0, wb_stall = 1'b0;
    logic [AW-1:0] alu_rd = '0, lsu_rd = '0, raddr1 = '0, raddr2 = '0;
    logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
    logic alu_ready, lsu_ready, regwrite, fwd_hit1, fwd_hit2;
    logic [AW-1:0] waddr;
    logic [XLEN-1:0] wdata, fwd_data1, fwd_data2;
    logic [2:0] pending;

    int n_checks = 0;
    int n_fail = 0;
    wb_entry_t pend[$];
    wb_entry_t exp_q[$];

    regfile_wb_writer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_stall(wb_stall), .regwrite(regwrite), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN:0] model_fwd(input logic [AW-1:0] ra);
        logic [XLEN:0] r;
        r = '0;
        if (ra != 0)
            foreach (pend[i]) if (pend[i].rd == ra) r = {1'b1, pend[i].data};
        return r;
    endfunction

    // reference model: a plain queue of accepted, not-yet-retired writes
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            exp_q.delete();
        end else begin
            automatic bit p = pend.size() > 0 && !wb_stall;
            automatic bit lr = pend.size() < DEPTH || p;
            if (p) void'(pend.pop_front());
            if (lsu_valid && lr) begin
                if (lsu_rd != 0) begin
                    pend.push_back('{rd: lsu_rd, data: lsu_data});
                    exp_q.push_back('{rd: lsu_rd, data: lsu_data});
                end
            end else if (alu_valid && lr && alu_rd != 0) begin
                pend.push_back('{rd: alu_rd, data: alu_data});
                exp_q.push_back('{rd: alu_rd, data: alu_data});
            end
        end
    end

    // monitor: compares every observable output against the model mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            check("rst_regwrite", regwrite, 0);
            check("rst_pending", pending, 0);
            check("rst_waddr", waddr, 0);
            check("rst_wdata", wdata, 0);
            check("rst_fwd_hit1", fwd_hit1, 0);
            check("rst_fwd_data1", fwd_data1, 0);
        end else begin
            automatic bit p = pend.size() > 0 && !wb_stall;
            automatic bit lr = pend.size() < DEPTH || p;
            automatic logic [XLEN:0] f1 = model_fwd(raddr1);
            automatic logic [XLEN:0] f2 = model_fwd(raddr2);
            check("pending", pending, pend.size());
            check("regwrite", regwrite, p);
            check("lsu_ready", lsu_ready, lr);
            check("alu_ready", alu_ready, lr && !lsu_valid);
            check("fwd_hit1", fwd_hit1, f1[XLEN]);
            check("fwd_data1", fwd_data1, f1[XLEN-1:0]);
            check("fwd_hit2", fwd_hit2, f2[XLEN]);
            check("fwd_data2", fwd_data2, f2[XLEN-1:0]);
            if (regwrite) begin
                if (exp_q.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    automatic wb_entry_t e = exp_q.pop_front();
                    check("waddr", waddr, e.rd);
                    check("wdata", wdata, e.data);
                end
            end else begin
                check("idle_waddr", waddr, 0);
                check("idle_wdata", wdata, 0);
            end
        end
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        // single ALU write
        alu_valid = 1; alu_rd = 1; alu_data = 32'hAAAA_AAAA;
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("single_regwrite", regwrite, 1);
        check("single_wdata", wdata, 32'hAAAA_AAAA);
        repeat (2) tick();
        // simultaneous producers: LSU first
        alu_valid = 1; alu_rd = 2; alu_data = 32'h5555_5555;
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h1234_5678;
        @(negedge clk);
        check("simul_alu_ready", alu_ready, 0);
        tick();
        lsu_valid = 0;
        tick();
        alu_valid = 0;
        repeat (3) tick();
        // x0 filter
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("x0_lsu_ready", lsu_ready, 1);
        tick();
        lsu_valid = 0;
        @(negedge clk);
        check("x0_pending", pending, 0);
        tick();
        // stall to full, then release with the fifth result still offered
        wb_stall = 1;
        for (int r = 4; r < 8; r++) begin
            alu_valid = 1; alu_rd = AW'(r); alu_data = 32'h100 + r;
            tick();
        end
        alu_rd = 8; alu_data = 32'h108;
        @(negedge clk);
        check("full_pending", pending, 4);
        check("full_alu_ready", alu_ready, 0);
        tick();
        wb_stall = 0;
        tick();
        alu_valid = 0;
        repeat (6) tick();
        // forwarding picks the youngest match
        wb_stall = 1;
        alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
        tick();
        alu_data = 32'h22;
        tick();
        alu_valid = 0; raddr1 = 5; raddr2 = 0;
        @(negedge clk);
        check("fwd_youngest_hit", fwd_hit1, 1);
        check("fwd_youngest_data", fwd_data1, 32'h22);
        check("fwd_x0_hit", fwd_hit2, 0);
        tick();
        wb_stall = 0; raddr1 = 0;
        repeat (4) tick();
        // reset mid-operation
        wb_stall = 1;
        for (int r = 9; r < 12; r++) begin
            alu_valid = 1; alu_rd = AW'(r); alu_data = 32'h900 + r;
            tick();
        end
        alu_valid = 0;
        @(negedge clk);
        check("pre_reset_pending", pending, 3);
        tick();
        wb_stall = 0; reset = 1;
        @(negedge clk);
        check("midrst_regwrite", regwrite, 0);
        check("midrst_pending", pending, 0);
        tick();
        reset = 0;
        repeat (4) tick();
        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            alu_valid = $urandom_range(0, 1);
            alu_rd = AW'($urandom_range(0, 7));
            alu_data = $urandom;
            lsu_valid = ($urandom_range(0, 2) == 0);
            lsu_rd = AW'($urandom_range(0, 7));
            lsu_data = $urandom;
            wb_stall = ($urandom_range(0, 9) < 3);
            raddr1 = AW'($urandom_range(0, 7));
            raddr2 = AW'($urandom_range(0, 7));
            tick();
        end
        alu_valid = 0; lsu_valid = 0; wb_stall = 0;
        repeat (8) tick();
        @(negedge clk);
        check("drain_scoreboard_empty", exp_q.size(), 0);
        check("drain_pending", pending, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
